// File: rtl/io_sequencer.sv
// io_sequencer
// ------------
// Multi-cycle sequencer for the IN / OUT / HLT instructions. It sits between
// the control unit and the PC / register-file write path.
//   IN  : stalls the PC until the operator presses the (conditioned) button,
//         then commits the switch value as a single register write.
//   OUT : latches dadoOut into the display register without stalling.
//   HLT : freezes the core until reset.
//
// Optional feature macro: IO_DEBOUNCE_EN
//   defined   -> button level is accepted only after DEBOUNCE_CYCLES
//                consecutive cycles of a stable new level.
//   undefined -> the synchronized button is used directly (for simulation
//                or boards with hardware-debounced buttons); DEBOUNCE_CYCLES
//                is ignored.
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   escreverIn     in   IN decoded by the control unit
//   escreverOut    in   OUT decoded by the control unit
//   halt           in   HLT decoded by the control unit
//   escreveR       in   register write request from the control unit
//   botao          in   raw asynchronous active-high push button
//   chaves         in   raw switches (quasi-static)
//   dadoOut        in   register value driven for OUT
//   pcEnable       out  PC may advance this cycle (combinational)
//   escreveRGated  out  final register-file write enable (combinational)
//   dadoIn         out  captured switch value, zero-extended (registered)
//   display        out  last OUT value (registered)
//   esperando      out  waiting on the operator (registered)
//   halted         out  core halted (registered)
module io_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  escreverIn,
  input  logic                  escreverOut,
  input  logic                  halt,
  input  logic                  escreveR,
  input  logic                  botao,
  input  logic [SW_WIDTH-1:0]   chaves,
  input  logic [DATA_WIDTH-1:0] dadoOut,
  output logic                  pcEnable,
  output logic                  escreveRGated,
  output logic [DATA_WIDTH-1:0] dadoIn,
  output logic [DATA_WIDTH-1:0] display,
  output logic                  esperando,
  output logic                  halted
);

  // Elaboration-time parameter sanity check.
  if (DEBOUNCE_CYCLES < 1 || SW_WIDTH > DATA_WIDTH) begin : g_bad_param
    $error("io_sequencer: DEBOUNCE_CYCLES must be >= 1 and SW_WIDTH <= DATA_WIDTH");
  end

  typedef enum logic [2:0] {
    S_EXEC         = 3'd0,
    S_WAIT_RELEASE = 3'd1,
    S_WAIT_PRESS   = 3'd2,
    S_COMMIT       = 3'd3,
    S_HALTED       = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_sync1;
  logic r_sync2;
  logic w_deb;
  logic w_pc;
  logic w_wr;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= botao;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_deb;

  // The counter measures how long the synchronized level has disagreed with
  // the accepted level; any agreement restarts the measurement.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (r_sync2 != r_deb) begin
      if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_deb <= ~r_deb;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_deb = r_deb;
`else
  assign w_deb = r_sync2;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EXEC;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. halt outranks escreverIn in EXEC. WAIT_RELEASE makes
  // sure a button still held from a previous IN cannot satisfy this one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EXEC: begin
        if (halt) begin
          w_next = S_HALTED;
        end else if (escreverIn) begin
          w_next = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: if (!w_deb) w_next = S_WAIT_PRESS;
      S_WAIT_PRESS:   if (w_deb)  w_next = S_COMMIT;
      S_COMMIT:       w_next = S_EXEC;
      S_HALTED:       w_next = S_HALTED;
      default:        w_next = S_EXEC;
    endcase
  end

  // Output logic. COMMIT is the cycle in which the IN instruction retires.
  always_comb begin
    w_pc = 1'b0;
    w_wr = 1'b0;
    case (r_state)
      S_EXEC: begin
        if (!halt && !escreverIn) begin
          w_pc = 1'b1;
          w_wr = escreveR;
        end
      end
      S_COMMIT: begin
        w_pc = 1'b1;
        w_wr = 1'b1;
      end
      default: begin
        w_pc = 1'b0;
        w_wr = 1'b0;
      end
    endcase
  end

  // Gating with reset_n keeps the core frozen while reset is held.
  assign pcEnable      = reset_n & w_pc;
  assign escreveRGated = reset_n & w_wr;

  // Registered outputs. esperando/halted follow the state being entered so
  // they line up with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dadoIn    <= '0;
      display   <= '0;
      esperando <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (r_state == S_EXEC && !halt && !escreverIn && escreverOut) begin
        display <= dadoOut;
      end
      if (r_state == S_WAIT_PRESS && w_deb) begin
        dadoIn <= DATA_WIDTH'(chaves);
      end
      esperando <= (w_next == S_WAIT_RELEASE) || (w_next == S_WAIT_PRESS);
      halted    <= (w_next == S_HALTED);
    end
  end

endmodule

// File: tb/tb_io_sequencer.sv
// Testbench for io_sequencer: directed scenarios with randomized data,
// compared every cycle against a behavioural reference model.
module tb_io_sequencer;

  localparam int DW  = 32;
  localparam int SW  = 16;
  localparam int DEB = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          escreverIn, escreverOut, halt, escreveR, botao;
  logic [SW-1:0] chaves;
  logic [DW-1:0] dadoOut;
  logic          pcEnable, escreveRGated, esperando, halted;
  logic [DW-1:0] dadoIn, display;

  io_sequencer #(.DATA_WIDTH(DW), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset_n(reset_n), .escreverIn(escreverIn),
    .escreverOut(escreverOut), .halt(halt), .escreveR(escreveR),
    .botao(botao), .chaves(chaves), .dadoOut(dadoOut),
    .pcEnable(pcEnable), .escreveRGated(escreveRGated), .dadoIn(dadoIn),
    .display(display), .esperando(esperando), .halted(halted)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: where the instruction is in its life, not an encoding.
  bit            m_halt, m_wait_rel, m_wait_press, m_commit;
  bit            m_s1, m_s2, m_deb;
  bit            hist[$];
  logic [DW-1:0] m_dadoIn, m_display;
  logic          last_wr;

  task automatic model_reset();
    m_halt = 0; m_wait_rel = 0; m_wait_press = 0; m_commit = 0;
    m_s1 = 0; m_s2 = 0; m_deb = 0;
    hist.delete();
    m_dadoIn = '0; m_display = '0;
  endtask

  task automatic model_edge();
    bit deb_now;
    bit all_diff;
    if (!reset_n) begin
      model_reset();
      return;
    end
`ifdef IO_DEBOUNCE_EN
    deb_now = m_deb;
`else
    deb_now = m_s2;
`endif
    if (m_halt) begin
      m_halt = 1;
    end else if (m_commit) begin
      m_commit = 0;
    end else if (m_wait_rel) begin
      if (!deb_now) begin m_wait_rel = 0; m_wait_press = 1; end
    end else if (m_wait_press) begin
      if (deb_now) begin
        m_wait_press = 0; m_commit = 1; m_dadoIn = {16'h0000, chaves};
      end
    end else begin
      if (halt) m_halt = 1;
      else if (escreverIn) m_wait_rel = 1;
      else if (escreverOut) m_display = dadoOut;
    end
`ifdef IO_DEBOUNCE_EN
    // Accept a new level once the last DEB synchronized samples all disagree.
    hist.push_back(m_s2);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      all_diff = 1;
      foreach (hist[i]) if (hist[i] == m_deb) all_diff = 0;
      if (all_diff) begin m_deb = !m_deb; hist.delete(); end
    end
`else
    all_diff = 0;
`endif
    m_s2 = m_s1;
    m_s1 = botao;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step();
    bit idle;
    @(negedge clock);
    idle = !m_halt && !m_wait_rel && !m_wait_press && !m_commit;
    chk("pcEnable", {63'd0, pcEnable},
        {63'd0, reset_n && (m_commit || (idle && !halt && !escreverIn))});
    chk("escreveRGated", {63'd0, escreveRGated},
        {63'd0, reset_n && (m_commit || (idle && !halt && !escreverIn && escreveR))});
    chk("esperando", {63'd0, esperando}, {63'd0, m_wait_rel || m_wait_press});
    chk("halted", {63'd0, halted}, {63'd0, m_halt});
    chk("dadoIn", {32'd0, dadoIn}, {32'd0, m_dadoIn});
    chk("display", {32'd0, display}, {32'd0, m_display});
    last_wr = escreveRGated;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_in(input logic [SW-1:0] sw);
    chaves = sw; escreverIn = 1; step(); escreverIn = 0;
  endtask

  task automatic press(input int len);
    botao = 1; steps(len); botao = 0;
  endtask

  initial begin
    int lat, pulses, exp_lat;
    reset_n = 0; escreverIn = 0; escreverOut = 0; halt = 0; escreveR = 0;
    botao = 0; chaves = '0; dadoOut = '0; last_wr = 0;
    model_reset();
    steps(2);
    reset_n = 1;
    steps(3);

    // OUT: display updates on the edge, no stall
    dadoOut = 32'hDEADBEEF; escreverOut = 1; escreveR = 1; step();
    escreverOut = 0; step();
    chk("display_deadbeef", {32'd0, display}, 64'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      dadoOut = $urandom; escreverOut = 1; escreveR = 1'($urandom); step();
    end
    escreverOut = 0; escreveR = 0; steps(2);

    // IN with button released, then held: fixed latency, one-cycle commit
    do_in(16'hA5A5);
    steps(3);
    botao = 1; lat = 0; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (last_wr) begin pulses++; if (lat == 0) lat = i; end
    end
    botao = 0;
`ifdef IO_DEBOUNCE_EN
    exp_lat = DEB + 4;
`else
    exp_lat = 4;
`endif
    chk("in_latency", 64'(lat), 64'(exp_lat));
    chk("in_pulses", 64'(pulses), 64'd1);
    chk("dadoIn_a5a5", {32'd0, dadoIn}, 64'h0000A5A5);
    steps(10);

    // Short glitch during WAIT_PRESS, then a proper press
    do_in(16'($urandom));
    steps(2);
    press(2);
    steps(8);
    press(10);
    steps(10);

    // Back-to-back IN with button still held from the first
    do_in(16'($urandom));
    steps(2);
    botao = 1; steps(12);
    chaves = 16'h0003; escreverIn = 1; step(); escreverIn = 0;
    steps(8);
    chk("held_waits", {63'd0, esperando}, 64'd1);
    botao = 0; steps(10);
    press(12);
    steps(10);
    chk("dadoIn_0003", {32'd0, dadoIn}, 64'h00000003);

    // Reset in the middle of WAIT_PRESS
    do_in(16'($urandom));
    steps(3);
    botao = 1; step();
    reset_n = 0; model_reset(); step();
    reset_n = 1; botao = 0;
    steps(5);
    chk("rst_dadoIn", {32'd0, dadoIn}, 64'd0);

    // halt together with IN: frozen until reset
    escreveR = 1; halt = 1; escreverIn = 1; step();
    halt = 0; escreverIn = 0;
    for (int i = 0; i < 3; i++) begin
      dadoOut = $urandom; escreverOut = 1; chaves = 16'($urandom);
      press(8); escreverOut = 0; steps(6);
    end
    chk("halted_hold", {63'd0, halted}, 64'd1);
    reset_n = 0; model_reset(); step();
    reset_n = 1; escreveR = 0; steps(3);

    // Randomized IN/OUT mix
    for (int n = 0; n < 8; n++) begin
      escreveR = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        dadoOut = $urandom; escreverOut = 1; step(); escreverOut = 0;
      end
      do_in(16'($urandom));
      steps($urandom_range(0, 4));
      press($urandom_range(1, 12));
      steps($urandom_range(4, 8));
      press(DEB + 6);
      steps(DEB + 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
